stk_cmd_mux: RTL and testbench
==============================

STK_CMD_MUX -- requirements
Module: stk_cmd_mux

Interface
REQ-001 SHALL have parameter N_ENG, default 8, meaning number of client engines (2^ENGID_W).
REQ-002 SHALL have parameter W, default 32, meaning push/pop data width.
REQ-003 SHALL have parameter MAX_OUT, default 4, meaning maximum outstanding POPs per engine.
REQ-004 SHALL have port clk  in  1  single clock, all state rising-edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port eng_req_vld_i  in  N_ENG  per-engine request valid.
REQ-007 SHALL have port eng_req_opcode_i  in  N_ENG*OPCODE_W  per-engine opcode_t.
REQ-008 SHALL have port eng_req_dat_i  in  N_ENG*W  per-engine push data.
REQ-009 SHALL have port eng_req_rdy_o  out  N_ENG  per-engine accept, one-hot or zero.
REQ-010 SHALL have port cmd_vld_o  out  1  command to stack valid.
REQ-011 SHALL have port cmd_opcode_o  out  OPCODE_W  PUSH or POP only.
REQ-012 SHALL have port cmd_engid_o  out  ENGID_W  issuing engine.
REQ-013 SHALL have port cmd_dat_o  out  W  push data, zero for POP.
REQ-014 SHALL have port cmd_rdy_i  in  1  stack accepts command.
REQ-015 SHALL have port rsp_vld_i  in  1  pop response valid (always accepted).
REQ-016 SHALL have port rsp_engid_i  in  ENGID_W  response destination.
REQ-017 SHALL have port rsp_dat_i  in  W  popped data.
REQ-018 SHALL have port rsp_empty_i  in  1  pop hit empty stack.
REQ-019 SHALL have port eng_rsp_vld_o  out  N_ENG  one-hot response strobe.
REQ-020 SHALL have port eng_rsp_dat_o  out  W  response data (shared bus).
REQ-021 SHALL have port eng_rsp_empty_o  out  1  response empty flag.
REQ-022 SHALL have port err_o  out  2  sticky: [0] INV opcode received, [1] unexpected response.

Function
REQ-023 Engine e SHALL be eligible when vld set and (opcode != POP or pop_cnt[e] < MAX_OUT).
REQ-024 Arbitration SHALL be round-robin; search starts at engine after last granted; pointer advances only on grant.
REQ-025 A grant SHALL occur only when output register empty or cmd_rdy_i high in the same cycle.
REQ-026 eng_req_rdy_o SHALL be combinational from grant; handshake = vld & rdy.
REQ-027 Granted PUSH/POP SHALL appear on cmd_* the following cycle (1-cycle latency), held stable until cmd_rdy_i.
REQ-028 Granted NOP SHALL be consumed with no command issued and no output-register use; may be granted when output register full.
REQ-029 Granted INV SHALL be consumed, not forwarded, and set err_o[0].
REQ-030 pop_cnt[e] SHALL increment on POP grant, decrement on rsp_vld_i for e; both same cycle: unchanged.
REQ-031 Response for engine with pop_cnt==0 SHALL set err_o[1], SHALL NOT be forwarded, counter SHALL stay 0.
REQ-032 Valid response SHALL be registered: eng_rsp_vld_o[rsp_engid_i], eng_rsp_dat_o, eng_rsp_empty_o asserted exactly one cycle after rsp_vld_i.
REQ-033 eng_rsp_dat_o/eng_rsp_empty_o SHALL hold last value when no strobe.
REQ-034 Back-to-back: with cmd_rdy_i held high, one command per cycle SHALL be sustained.

Reset
REQ-035 On rst: cmd_vld_o=0, cmd_opcode_o=NOP, cmd_engid_o=0, cmd_dat_o=0, eng_rsp_vld_o=0, eng_rsp_dat_o=0, eng_rsp_empty_o=0, err_o=0, all pop_cnt=0, RR pointer=engine N_ENG-1 (so engine 0 first).
REQ-036 rst mid-operation SHALL discard the pending command and all outstanding-pop state; eng_req_rdy_o SHALL be 0 while rst high.

Structure
REQ-037 opcode_t, OPCODE_W, ENGID_W, engid_t SHALL come from stk_pkg; an stk_rsp_t struct (engid, dat, empty) SHALL be added to stk_pkg.
REQ-038 Round-robin arbiter SHALL be a sub-module stk_rr_arb (req vector, advance, one-hot grant).

Verification
REQ-039 Engines 0,3,5 PUSH simultaneously, cmd_rdy_i=1 -> cmd_engid_o 0,3,5 on cycles 1,2,3, eng_req_rdy_o one-hot each.
REQ-040 Engine 2 issues 5 POPs, no responses -> 4 forwarded, 5th held (rdy=0); rsp engid=2 -> 5th granted next cycle.
REQ-041 PUSH 0xDEADBEEF from engine 1 with cmd_rdy_i=0 for 3 cycles -> cmd_* stable 3 cycles, single transfer.
REQ-042 rsp_vld_i engid=4 dat=0x12 with pop_cnt[4]=1 -> eng_rsp_vld_o=8'h10, dat=0x12 next cycle; repeat -> err_o[1]=1, no strobe.
REQ-043 Engine 6 sends INV then NOP -> both consumed, no cmd_vld_o, err_o=2'b01.
REQ-044 rst asserted with cmd pending and pop_cnt[2]=3 -> next cycle cmd_vld_o=0, engine 2 accepted 4 new POPs.

Source files
------------

// File: rtl/stk_pkg.sv
// Shared types for the stack command path.
// Provides the engine opcode encoding, engine-id type and the pop-response payload.
package stk_pkg;

    localparam int unsigned OPCODE_W = 2;
    localparam int unsigned ENGID_W  = 3;
    localparam int unsigned DAT_W    = 32;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP  = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_INV  = 2'd3
    } opcode_t;

    typedef logic [ENGID_W-1:0] engid_t;

    typedef struct packed {
        engid_t             engid;
        logic [DAT_W-1:0]   dat;
        logic               empty;
    } stk_rsp_t;

    // True for opcodes that travel on to the stack.
    function automatic logic is_stack_cmd(opcode_t op);
        return (op == OP_PUSH) || (op == OP_POP);
    endfunction

endpackage

// File: rtl/stk_rr_arb.sv
// Round-robin arbiter.
// Ports: clk, rst (sync, active high), req (request vector), advance (a grant was
// taken this cycle), gnt_c (combinational one-hot grant, zero when no request).
// The search starts at the requester after the last winner; reset points at N-1.
module stk_rr_arb #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt_c
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] idx;
    logic             found;

    // Rotating priority search beginning just after the last winner.
    always_comb begin
        gnt_c   = '0;
        win_idx = last_q;
        idx     = '0;
        found   = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = IDX_W'((32'(last_q) + i) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt_c[idx] = 1'b1;
                win_idx    = idx;
            end
        end
    end

    // Pointer moves only when the grant is actually consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IDX_W'(N - 1);
        end else if (advance) begin
            last_q <= win_idx;
        end
    end

endmodule

// File: rtl/stk_cmd_mux.sv
// Multiplexes per-engine stack requests onto one command port and routes pop
// responses back to the issuing engine.
// Ports: eng_req_* (per-engine request, rdy is the combinational grant),
// cmd_* (registered command to the stack, held until cmd_rdy_i),
// rsp_* (pop responses from the stack), eng_rsp_* (registered response strobe
// and shared data bus), err_o (sticky: [0] INV seen, [1] unexpected response).
module stk_cmd_mux
    import stk_pkg::*;
#(
    parameter int unsigned N_ENG   = 8,
    parameter int unsigned W       = 32,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_ENG-1:0]          eng_req_vld_i,
    input  logic [N_ENG*OPCODE_W-1:0] eng_req_opcode_i,
    input  logic [N_ENG*W-1:0]        eng_req_dat_i,
    output logic [N_ENG-1:0]          eng_req_rdy_o,
    output logic                      cmd_vld_o,
    output logic [OPCODE_W-1:0]       cmd_opcode_o,
    output logic [ENGID_W-1:0]        cmd_engid_o,
    output logic [W-1:0]              cmd_dat_o,
    input  logic                      cmd_rdy_i,
    input  logic                      rsp_vld_i,
    input  logic [ENGID_W-1:0]        rsp_engid_i,
    input  logic [W-1:0]              rsp_dat_i,
    input  logic                      rsp_empty_i,
    output logic [N_ENG-1:0]          eng_rsp_vld_o,
    output logic [W-1:0]              eng_rsp_dat_o,
    output logic                      eng_rsp_empty_o,
    output logic [1:0]                err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    opcode_t          req_op [N_ENG];
    logic [CNT_W-1:0] pop_cnt_q [N_ENG];
    logic [N_ENG-1:0] req_elig_c;
    logic [N_ENG-1:0] gnt_c;
    logic [N_ENG-1:0] pop_inc_c;
    logic [N_ENG-1:0] pop_dec_c;
    logic             out_free_c;
    logic             gnt_any_c;
    engid_t           gnt_idx_c;
    opcode_t          gnt_op_c;
    logic [W-1:0]     gnt_dat_c;
    logic             rsp_known_c;
    logic             rsp_vld_q;
    stk_rsp_t         rsp_q;

    assign out_free_c  = !cmd_vld_o || cmd_rdy_i;
    assign rsp_known_c = (pop_cnt_q[rsp_engid_i] != '0);

    // Request qualification: NOP/INV never need the output register, so they
    // stay eligible while a command is stalled.
    always_comb begin
        req_elig_c = '0;
        for (int unsigned e = 0; e < N_ENG; e++) begin
            req_op[e] = opcode_t'(eng_req_opcode_i[e*OPCODE_W +: OPCODE_W]);
            case (req_op[e])
                OP_PUSH: req_elig_c[e] = eng_req_vld_i[e] && out_free_c;
                OP_POP:  req_elig_c[e] = eng_req_vld_i[e] && out_free_c &&
                                         (pop_cnt_q[e] < CNT_W'(MAX_OUT));
                default: req_elig_c[e] = eng_req_vld_i[e];
            endcase
            if (rst) req_elig_c[e] = 1'b0;
        end
    end

    stk_rr_arb #(.N(N_ENG)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_elig_c),
        .advance (gnt_any_c),
        .gnt_c   (gnt_c)
    );

    assign gnt_any_c     = |gnt_c;
    assign eng_req_rdy_o = gnt_c;

    // One-hot grant to index, opcode and data of the winner.
    always_comb begin
        gnt_idx_c = '0;
        gnt_op_c  = OP_NOP;
        gnt_dat_c = '0;
        pop_inc_c = '0;
        pop_dec_c = '0;
        for (int unsigned e = 0; e < N_ENG; e++) begin
            if (gnt_c[e]) begin
                gnt_idx_c = ENGID_W'(e);
                gnt_op_c  = req_op[e];
                gnt_dat_c = eng_req_dat_i[e*W +: W];
            end
            pop_inc_c[e] = gnt_c[e] && (req_op[e] == OP_POP);
            pop_dec_c[e] = rsp_vld_i && (rsp_engid_i == ENGID_W'(e)) &&
                           (pop_cnt_q[e] != '0);
        end
    end

    // Command output register; a new grant only happens when it is free.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_vld_o    <= 1'b0;
            cmd_opcode_o <= OP_NOP;
            cmd_engid_o  <= '0;
            cmd_dat_o    <= '0;
        end else if (gnt_any_c && is_stack_cmd(gnt_op_c)) begin
            cmd_vld_o    <= 1'b1;
            cmd_opcode_o <= gnt_op_c;
            cmd_engid_o  <= gnt_idx_c;
            cmd_dat_o    <= (gnt_op_c == OP_POP) ? '0 : gnt_dat_c;
        end else if (cmd_rdy_i) begin
            cmd_vld_o    <= 1'b0;
        end
    end

    // Outstanding POP count per engine; simultaneous issue and return cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned e = 0; e < N_ENG; e++) pop_cnt_q[e] <= '0;
        end else begin
            for (int unsigned e = 0; e < N_ENG; e++) begin
                if (pop_inc_c[e] && !pop_dec_c[e]) begin
                    pop_cnt_q[e] <= pop_cnt_q[e] + CNT_W'(1);
                end else if (pop_dec_c[e] && !pop_inc_c[e]) begin
                    pop_cnt_q[e] <= pop_cnt_q[e] - CNT_W'(1);
                end
            end
        end
    end

    // Response register and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q <= 1'b0;
            rsp_q     <= '0;
            err_o     <= '0;
        end else begin
            rsp_vld_q <= rsp_vld_i && rsp_known_c;
            if (rsp_vld_i && rsp_known_c) begin
                rsp_q <= '{engid: rsp_engid_i, dat: DAT_W'(rsp_dat_i), empty: rsp_empty_i};
            end
            if (gnt_any_c && (gnt_op_c == OP_INV)) err_o[0] <= 1'b1;
            if (rsp_vld_i && !rsp_known_c)         err_o[1] <= 1'b1;
        end
    end

    assign eng_rsp_vld_o   = rsp_vld_q ? (N_ENG'(1) << rsp_q.engid) : '0;
    assign eng_rsp_dat_o   = W'(rsp_q.dat);
    assign eng_rsp_empty_o = rsp_q.empty;

endmodule

// File: tb/tb_stk_cmd_mux.sv
// Self-checking bench for stk_cmd_mux: expected commands and responses are
// queued as stimulus is driven and compared as the DUT presents them.
module tb_stk_cmd_mux;
    import stk_pkg::*;

    localparam int unsigned N = 8;
    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   eng_req_vld;
    logic [N*2-1:0] eng_req_op;
    logic [N*W-1:0] eng_req_dat;
    logic [N-1:0]   eng_req_rdy;
    logic           cmd_vld;
    logic [1:0]     cmd_op;
    logic [2:0]     cmd_engid;
    logic [W-1:0]   cmd_dat;
    logic           cmd_rdy;
    logic           rsp_vld;
    logic [2:0]     rsp_engid;
    logic [W-1:0]   rsp_dat;
    logic           rsp_empty;
    logic [N-1:0]   eng_rsp_vld;
    logic [W-1:0]   eng_rsp_dat;
    logic           eng_rsp_empty;
    logic [1:0]     err;

    typedef struct packed { logic [2:0] engid; logic [1:0] op; logic [31:0] dat; } exp_cmd_t;
    typedef struct packed { logic [7:0] vld; logic [31:0] dat; logic empty; } exp_rsp_t;

    exp_cmd_t exp_cmd_q[$];
    exp_rsp_t exp_rsp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stk_cmd_mux #(.N_ENG(8), .W(32), .MAX_OUT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .eng_req_vld_i    (eng_req_vld),
        .eng_req_opcode_i (eng_req_op),
        .eng_req_dat_i    (eng_req_dat),
        .eng_req_rdy_o    (eng_req_rdy),
        .cmd_vld_o        (cmd_vld),
        .cmd_opcode_o     (cmd_op),
        .cmd_engid_o      (cmd_engid),
        .cmd_dat_o        (cmd_dat),
        .cmd_rdy_i        (cmd_rdy),
        .rsp_vld_i        (rsp_vld),
        .rsp_engid_i      (rsp_engid),
        .rsp_dat_i        (rsp_dat),
        .rsp_empty_i      (rsp_empty),
        .eng_rsp_vld_o    (eng_rsp_vld),
        .eng_rsp_dat_o    (eng_rsp_dat),
        .eng_rsp_empty_o  (eng_rsp_empty),
        .err_o            (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Negedge sample: scoreboards compare any command transfer / response strobe.
    task automatic sample();
        exp_cmd_t c;
        exp_rsp_t r;
        @(negedge clk);
        if (cmd_vld && cmd_rdy) begin
            checks++;
            if (exp_cmd_q.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected: got eng=%0d op=%0d dat=%h, required no command",
                         cmd_engid, cmd_op, cmd_dat);
            end else begin
                c = exp_cmd_q.pop_front();
                if ({cmd_engid, cmd_op, cmd_dat} !== {c.engid, c.op, c.dat}) begin
                    errors++;
                    $display("FAIL cmd_order: got eng=%0d op=%0d dat=%h, required eng=%0d op=%0d dat=%h",
                             cmd_engid, cmd_op, cmd_dat, c.engid, c.op, c.dat);
                end
            end
        end
        if (eng_rsp_vld != '0) begin
            checks++;
            if (exp_rsp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got strobe=%h dat=%h, required no strobe",
                         eng_rsp_vld, eng_rsp_dat);
            end else begin
                r = exp_rsp_q.pop_front();
                if ({eng_rsp_vld, eng_rsp_dat, eng_rsp_empty} !== {r.vld, r.dat, r.empty}) begin
                    errors++;
                    $display("FAIL rsp_data: got strobe=%h dat=%h empty=%b, required strobe=%h dat=%h empty=%b",
                             eng_rsp_vld, eng_rsp_dat, eng_rsp_empty, r.vld, r.dat, r.empty);
                end
            end
        end
    endtask

    task automatic set_req(input int unsigned e, input opcode_t op, input logic [31:0] d);
        eng_req_vld[e]         = 1'b1;
        eng_req_op[e*2 +: 2]   = op;
        eng_req_dat[e*W +: W]  = d;
    endtask

    task automatic push_cmd(input int unsigned e, input opcode_t op, input logic [31:0] d);
        exp_cmd_t c;
        c.engid = 3'(e);
        c.op    = op;
        c.dat   = d;
        exp_cmd_q.push_back(c);
    endtask

    task automatic send_rsp(input int unsigned e, input logic [31:0] d, input logic emp, input logic expect_fwd);
        exp_rsp_t r;
        rsp_vld   = 1'b1;
        rsp_engid = 3'(e);
        rsp_dat   = d;
        rsp_empty = emp;
        if (expect_fwd) begin
            r.vld   = 8'(1) << e;
            r.dat   = d;
            r.empty = emp;
            exp_rsp_q.push_back(r);
        end
    endtask

    // Bounded wait for both scoreboards to empty.
    task automatic drain(input string name);
        rsp_vld = 1'b0;
        for (int i = 0; i < 12 && (exp_cmd_q.size() != 0 || exp_rsp_q.size() != 0); i++) begin
            sample();
            tick();
        end
        checks++;
        if (exp_cmd_q.size() != 0 || exp_rsp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d cmds %0d rsps still pending, required 0",
                     name, exp_cmd_q.size(), exp_rsp_q.size());
            exp_cmd_q.delete();
            exp_rsp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        eng_req_vld = '1;
        eng_req_op  = {N{2'b01}};
        eng_req_dat = '0;
        cmd_rdy = 1'b1;
        rsp_vld = 1'b0; rsp_engid = '0; rsp_dat = '0; rsp_empty = 1'b0;
        tick();
        sample();
        checks++;
        if (eng_req_rdy !== 8'h00) begin
            errors++; $display("FAIL reset_rdy: got %h, required 00", eng_req_rdy);
        end
        checks++;
        if ({cmd_vld, cmd_op, cmd_engid, cmd_dat} !== {1'b0, 2'b00, 3'd0, 32'd0}) begin
            errors++; $display("FAIL reset_cmd: got vld=%b op=%0d eng=%0d dat=%h, required all zero",
                               cmd_vld, cmd_op, cmd_engid, cmd_dat);
        end
        checks++;
        if ({eng_rsp_vld, eng_rsp_dat, eng_rsp_empty} !== 41'd0) begin
            errors++; $display("FAIL reset_rsp: got strobe=%h dat=%h empty=%b, required zero",
                               eng_rsp_vld, eng_rsp_dat, eng_rsp_empty);
        end
        checks++;
        if (err !== 2'b00) begin
            errors++; $display("FAIL reset_err: got %b, required 00", err);
        end
        eng_req_vld = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_rr();
        int unsigned order [3] = '{0, 3, 5};
        logic [N-1:0] g;
        cmd_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(order[i], OP_PUSH, 32'h1000_0000 + 32'(order[i]));
            push_cmd(order[i], OP_PUSH, 32'h1000_0000 + 32'(order[i]));
        end
        for (int i = 0; i < 3; i++) begin
            sample();
            checks++;
            if (eng_req_rdy !== (8'(1) << order[i])) begin
                errors++; $display("FAIL rr_grant%0d: got %h, required %h", i, eng_req_rdy, 8'(1) << order[i]);
            end
            g = eng_req_rdy;
            tick();
            eng_req_vld = eng_req_vld & ~g;
        end
        drain("rr");
    endtask

    task automatic test_stall();
        cmd_rdy = 1'b0;
        set_req(1, OP_PUSH, 32'hDEAD_BEEF);
        push_cmd(1, OP_PUSH, 32'hDEAD_BEEF);
        sample();
        checks++;
        if (eng_req_rdy !== 8'h02) begin
            errors++; $display("FAIL stall_grant: got %h, required 02", eng_req_rdy);
        end
        tick();
        eng_req_vld = '0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) set_req(7, OP_NOP, 32'h0);
            sample();
            checks++;
            if ({cmd_vld, cmd_op, cmd_engid, cmd_dat} !== {1'b1, 2'b01, 3'd1, 32'hDEAD_BEEF}) begin
                errors++; $display("FAIL stall_hold%0d: got vld=%b op=%0d eng=%0d dat=%h, required 1 1 1 deadbeef",
                                   i, cmd_vld, cmd_op, cmd_engid, cmd_dat);
            end
            if (i == 1) begin
                checks++;
                if (eng_req_rdy !== 8'h80) begin
                    errors++; $display("FAIL stall_nop_grant: got %h, required 80", eng_req_rdy);
                end
            end
            tick();
            eng_req_vld = '0;
        end
        cmd_rdy = 1'b1;
        sample();
        tick();
        sample();
        checks++;
        if (cmd_vld !== 1'b0) begin
            errors++; $display("FAIL stall_single: got cmd_vld=%b, required 0", cmd_vld);
        end
        tick();
        drain("stall");
    endtask

    task automatic test_pop_limit();
        int grants = 0;
        cmd_rdy = 1'b1;
        set_req(2, OP_POP, 32'h0);
        for (int i = 0; i < 5; i++) push_cmd(2, OP_POP, 32'h0);
        for (int i = 0; i < 8; i++) begin
            sample();
            if (eng_req_rdy[2]) grants++;
            tick();
        end
        checks++;
        if (grants != 4) begin
            errors++; $display("FAIL pop_limit_count: got %0d grants, required 4", grants);
        end
        send_rsp(2, 32'h0000_00AA, 1'b0, 1'b1);
        sample();
        checks++;
        if (eng_req_rdy !== 8'h00) begin
            errors++; $display("FAIL pop_limit_held: got %h, required 00", eng_req_rdy);
        end
        tick();
        rsp_vld = 1'b0;
        sample();
        checks++;
        if (eng_req_rdy !== 8'h04) begin
            errors++; $display("FAIL pop_limit_release: got %h, required 04", eng_req_rdy);
        end
        tick();
        eng_req_vld = '0;
        for (int i = 0; i < 4; i++) begin
            send_rsp(2, 32'h100 + 32'(i), (i == 3), 1'b1);
            sample();
            tick();
        end
        drain("pop_limit");
    endtask

    task automatic test_inv_nop();
        set_req(6, OP_INV, 32'h5555_5555);
        sample();
        checks++;
        if (eng_req_rdy !== 8'h40) begin
            errors++; $display("FAIL inv_grant: got %h, required 40", eng_req_rdy);
        end
        tick();
        set_req(6, OP_NOP, 32'h6666_6666);
        sample();
        checks++;
        if (eng_req_rdy !== 8'h40) begin
            errors++; $display("FAIL nop_grant: got %h, required 40", eng_req_rdy);
        end
        tick();
        eng_req_vld = '0;
        sample();
        checks++;
        if (cmd_vld !== 1'b0 || err !== 2'b01) begin
            errors++; $display("FAIL inv_nop_result: got cmd_vld=%b err=%b, required 0 01", cmd_vld, err);
        end
        tick();
        drain("inv_nop");
    endtask

    task automatic test_rsp();
        set_req(4, OP_POP, 32'h0);
        push_cmd(4, OP_POP, 32'h0);
        sample();
        tick();
        eng_req_vld = '0;
        sample();
        tick();
        send_rsp(4, 32'h12, 1'b0, 1'b1);
        sample();
        tick();
        rsp_vld = 1'b0;
        sample();
        checks++;
        if (eng_rsp_vld !== 8'h10 || eng_rsp_dat !== 32'h12) begin
            errors++; $display("FAIL rsp_route: got strobe=%h dat=%h, required 10 00000012", eng_rsp_vld, eng_rsp_dat);
        end
        tick();
        send_rsp(4, 32'h34, 1'b1, 1'b0);
        sample();
        tick();
        rsp_vld = 1'b0;
        sample();
        checks++;
        if (eng_rsp_vld !== 8'h00 || err !== 2'b11 || eng_rsp_dat !== 32'h12) begin
            errors++; $display("FAIL rsp_unexpected_err: got strobe=%h err=%b dat=%h, required 00 11 00000012",
                               eng_rsp_vld, err, eng_rsp_dat);
        end
        tick();
        drain("rsp");
    endtask

    task automatic test_back_to_back();
        int xfers = 0;
        logic gap = 1'b0;
        logic [N-1:0] g;
        logic [31:0] d;
        cmd_rdy = 1'b1;
        // Last grant so far went to engine 4, so the rotation starts at 5.
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            set_req((5 + i) % 8, OP_PUSH, d);
            push_cmd((5 + i) % 8, OP_PUSH, d);
        end
        for (int i = 0; i < 14; i++) begin
            sample();
            if (cmd_vld) xfers++;
            else if (xfers > 0 && xfers < 8) gap = 1'b1;
            g = eng_req_rdy;
            tick();
            eng_req_vld = eng_req_vld & ~g;
        end
        checks++;
        if (xfers != 8 || gap) begin
            errors++; $display("FAIL b2b_rate: got %0d transfers gap=%b, required 8 gap=0", xfers, gap);
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        int grants = 0;
        cmd_rdy = 1'b1;
        set_req(2, OP_POP, 32'h0);
        for (int i = 0; i < 3; i++) begin
            push_cmd(2, OP_POP, 32'h0);
            sample();
            tick();
        end
        eng_req_vld = '0;
        sample();
        tick();
        cmd_rdy = 1'b0;
        set_req(1, OP_PUSH, 32'h0000_CAFE);
        sample();
        tick();
        eng_req_vld = '0;
        sample();
        checks++;
        if (cmd_vld !== 1'b1) begin
            errors++; $display("FAIL rstmid_pending: got cmd_vld=%b, required 1", cmd_vld);
        end
        tick();
        rst = 1'b1;
        set_req(2, OP_POP, 32'h0);
        sample();
        checks++;
        if (eng_req_rdy !== 8'h00) begin
            errors++; $display("FAIL rstmid_rdy: got %h, required 00", eng_req_rdy);
        end
        tick();
        rst = 1'b0;
        cmd_rdy = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(2, OP_POP, 32'h0);
        sample();
        checks++;
        if (cmd_vld !== 1'b0) begin
            errors++; $display("FAIL rstmid_discard: got cmd_vld=%b, required 0", cmd_vld);
        end
        if (eng_req_rdy[2]) grants++;
        tick();
        for (int i = 0; i < 7; i++) begin
            sample();
            if (eng_req_rdy[2]) grants++;
            tick();
        end
        checks++;
        if (grants != 4) begin
            errors++; $display("FAIL rstmid_pops: got %0d grants, required 4", grants);
        end
        eng_req_vld = '0;
        drain("rstmid");
    endtask

    initial begin
        test_reset();
        test_rr();
        test_stall();
        test_pop_limit();
        test_inv_nop();
        test_rsp();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
